// File: rtl/block_duty_gen_if.sv
// rtl/block_duty_gen_if.sv - raster timing in / duty-window out bundle for block_duty_gen
interface block_duty_gen_if #(
  parameter int V_BANDS = 8
);
  localparam int BW = $clog2(V_BANDS);

  logic          iVSync;
  logic          iDE;
  logic [23:0]   oH_Duty;
  logic          oV_Duty;
  logic          oBandDone;
  logic [BW-1:0] oBandIdx;
  logic          oFrameDone;
  logic          oErr;

  // Timing front end side: drives raster timing, observes the duty windows.
  modport master (
    output iVSync, iDE,
    input  oH_Duty, oV_Duty, oBandDone, oBandIdx, oFrameDone, oErr
  );

  // Duty generator side.
  modport slave (
    input  iVSync, iDE,
    output oH_Duty, oV_Duty, oBandDone, oBandIdx, oFrameDone, oErr
  );
endinterface

// File: rtl/block_duty_gen.sv
// rtl/block_duty_gen.sv - raster tracker driving 24 column-block enables and band/frame strobes (optional checker: BLOCK_DUTY_GEN_ERR_EN)
module block_duty_gen #(
  parameter int H_ACTIVE = 1920,
  parameter int V_ACTIVE = 1080,
  parameter int V_BANDS  = 8
) (
  input logic             iODCK,
  input logic             iRST,
  block_duty_gen_if.slave bus
);
  localparam int BLK_W  = H_ACTIVE / 24;
  localparam int BAND_H = V_ACTIVE / V_BANDS;
  localparam int CW     = $clog2(H_ACTIVE + 1);
  localparam int IW     = (BLK_W > 1) ? $clog2(BLK_W) : 1;
  localparam int LW     = (BAND_H > 1) ? $clog2(BAND_H) : 1;
  localparam int BW     = $clog2(V_BANDS);

  localparam logic [CW-1:0] COL_MAX   = CW'(H_ACTIVE);
  localparam logic [IW-1:0] IN_LAST   = IW'(BLK_W - 1);
  localparam logic [LW-1:0] LINE_LAST = LW'(BAND_H - 1);
  localparam logic [BW-1:0] BAND_LAST = BW'(V_BANDS - 1);
  localparam logic [4:0]    BLK_LAST  = 5'd23;

  // S_ABORT is the single low-V_Duty cycle that follows a mid-frame VSync.
  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_BAND_END, S_ABORT} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [IW-1:0] inblk_q, inblk_d;
  logic [4:0]    blk_q, blk_d;
  logic [LW-1:0] line_q, line_d;
  logic [BW-1:0] band_q, band_d;
  logic          de_q, de_d;
  logic [23:0]   h_duty_q, h_duty_d;
  logic          v_duty_q, v_duty_d;
  logic          band_done_q, band_done_d;
  logic          frame_done_q, frame_done_d;
  logic          clr_line, clr_frame;

  // Next-state, counter and registered-output decode for the raster FSM.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    inblk_d      = inblk_q;
    blk_d        = blk_q;
    line_d       = line_q;
    band_d       = band_q;
    de_d         = bus.iDE;
    h_duty_d     = '0;
    band_done_d  = 1'b0;
    frame_done_d = 1'b0;
    clr_line     = 1'b0;
    clr_frame    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.iVSync) begin
          state_d   = S_ACTIVE;
          clr_frame = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (bus.iVSync) begin
          // VSync wins over any pixel in the same cycle.
          state_d   = S_ABORT;
          clr_frame = 1'b1;
        end else if (bus.iDE) begin
          if (col_q < COL_MAX) begin
            h_duty_d = 24'd1 << blk_q;
            col_d    = col_q + 1'b1;
            if (inblk_q == IN_LAST) begin
              inblk_d = '0;
              if (blk_q != BLK_LAST) blk_d = blk_q + 1'b1;
            end else begin
              inblk_d = inblk_q + 1'b1;
            end
          end
        end else if (de_q) begin
          clr_line = 1'b1;
          if (line_q == LINE_LAST) begin
            line_d       = '0;
            state_d      = S_BAND_END;
            band_done_d  = 1'b1;
            frame_done_d = (band_q == BAND_LAST);
          end else begin
            line_d = line_q + 1'b1;
          end
        end
      end
      S_BAND_END: begin
        // Any pixel here lands in the max units' clear cycle and is dropped.
        if (bus.iVSync) begin
          state_d   = S_ABORT;
          clr_frame = 1'b1;
        end else if (band_q == BAND_LAST) begin
          state_d = S_IDLE;
          band_d  = '0;
        end else begin
          state_d = S_ACTIVE;
          band_d  = band_q + 1'b1;
        end
      end
      default: begin
        if (bus.iVSync) clr_frame = 1'b1;
        else            state_d   = S_ACTIVE;
      end
    endcase

    if (clr_line || clr_frame) begin
      col_d   = '0;
      inblk_d = '0;
      blk_d   = '0;
    end
    if (clr_frame) begin
      line_d = '0;
      band_d = '0;
    end

    v_duty_d = (state_d == S_ACTIVE);
  end

  // Raster state and output registers.
  always_ff @(posedge iODCK) begin
    if (!iRST) begin
      state_q      <= S_IDLE;
      col_q        <= '0;
      inblk_q      <= '0;
      blk_q        <= '0;
      line_q       <= '0;
      band_q       <= '0;
      de_q         <= 1'b0;
      h_duty_q     <= '0;
      v_duty_q     <= 1'b0;
      band_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      inblk_q      <= inblk_d;
      blk_q        <= blk_d;
      line_q       <= line_d;
      band_q       <= band_d;
      de_q         <= de_d;
      h_duty_q     <= h_duty_d;
      v_duty_q     <= v_duty_d;
      band_done_q  <= band_done_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.oH_Duty    = h_duty_q;
  assign bus.oV_Duty    = v_duty_q;
  assign bus.oBandDone  = band_done_q;
  assign bus.oBandIdx   = band_q;
  assign bus.oFrameDone = frame_done_q;

`ifdef BLOCK_DUTY_GEN_ERR_EN
  logic ovf_q, ovf_d;
  logic err_q, err_d;

  // Line-length overrun tracking and the sticky timing-error flag.
  always_comb begin
    ovf_d = ovf_q;
    err_d = err_q;
    if (state_q == S_ACTIVE && !bus.iVSync) begin
      if (bus.iDE && col_q == COL_MAX) begin
        ovf_d = 1'b1;
      end else if (!bus.iDE && de_q) begin
        if (col_q != COL_MAX || ovf_q) err_d = 1'b1;
        ovf_d = 1'b0;
      end
    end
    if (bus.iVSync && state_q != S_IDLE) begin
      err_d = 1'b1;
      ovf_d = 1'b0;
    end
    if (state_q == S_BAND_END && bus.iDE) err_d = 1'b1;
  end

  // Error checker registers; only reset clears the flag.
  always_ff @(posedge iODCK) begin
    if (!iRST) begin
      ovf_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      err_q <= err_d;
    end
  end

  assign bus.oErr = err_q;
`else
  assign bus.oErr = 1'b0;
`endif
endmodule

// File: tb/tb_block_duty_gen.sv
// tb/tb_block_duty_gen.sv - directed self-checking bench for block_duty_gen
module tb_block_duty_gen;
  localparam int H_ACTIVE = 48;
  localparam int V_ACTIVE = 8;
  localparam int V_BANDS  = 2;
`ifdef BLOCK_DUTY_GEN_ERR_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  logic iODCK = 1'b0;
  logic iRST  = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  block_duty_gen_if #(.V_BANDS(V_BANDS)) bus ();

  block_duty_gen #(
    .H_ACTIVE(H_ACTIVE),
    .V_ACTIVE(V_ACTIVE),
    .V_BANDS (V_BANDS)
  ) dut (
    .iODCK(iODCK),
    .iRST (iRST),
    .bus  (bus)
  );

  always #5 iODCK = ~iODCK;

  task automatic step(input logic vs, input logic de);
    bus.iVSync = vs;
    bus.iDE    = de;
    @(posedge iODCK);
    #1;
  endtask

  task automatic start();
    iRST = 1'b0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    iRST = 1'b1;
    step(1'b0, 1'b0);
  endtask

  task automatic send_line(input int n);
    for (int p = 0; p < n; p++) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    iRST = 1'b0;
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    n_checks++; if (bus.oH_Duty !== 24'h0) begin n_fail++; $display("FAIL reset_h_duty got %h exp %h", bus.oH_Duty, 24'h0); end
    n_checks++; if (bus.oV_Duty !== 1'b0) begin n_fail++; $display("FAIL reset_v_duty got %b exp 0", bus.oV_Duty); end
    n_checks++; if (bus.oBandDone !== 1'b0) begin n_fail++; $display("FAIL reset_band_done got %b exp 0", bus.oBandDone); end
    n_checks++; if (bus.oBandIdx !== 1'b0) begin n_fail++; $display("FAIL reset_band_idx got %h exp 0", bus.oBandIdx); end
    n_checks++; if (bus.oFrameDone !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done got %b exp 0", bus.oFrameDone); end
    n_checks++; if (bus.oErr !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", bus.oErr); end
    iRST = 1'b1;
    step(1'b0, 1'b1);
    n_checks++; if (bus.oV_Duty !== 1'b0 || bus.oH_Duty !== 24'h0) begin n_fail++; $display("FAIL idle_no_vsync got v=%b h=%h exp v=0 h=0", bus.oV_Duty, bus.oH_Duty); end
    step(1'b0, 1'b0);
  endtask

  task automatic test_first_line();
    logic [23:0] exp;
    start();
    step(1'b1, 1'b0);
    n_checks++; if (bus.oV_Duty !== 1'b1) begin n_fail++; $display("FAIL line_v_duty_rise got %b exp 1", bus.oV_Duty); end
    for (int p = 0; p < H_ACTIVE; p++) begin
      step(1'b0, 1'b1);
      exp = 24'h1 << (p / 2);
      n_checks++; if (bus.oH_Duty !== exp) begin n_fail++; $display("FAIL line_h_duty px%0d got %h exp %h", p, bus.oH_Duty, exp); end
    end
    step(1'b0, 1'b0);
    n_checks++; if (bus.oH_Duty !== 24'h0) begin n_fail++; $display("FAIL line_h_duty_blank got %h exp 0", bus.oH_Duty); end
    n_checks++; if (bus.oV_Duty !== 1'b1 || bus.oBandDone !== 1'b0) begin n_fail++; $display("FAIL line_end got v=%b done=%b exp v=1 done=0", bus.oV_Duty, bus.oBandDone); end
  endtask

  task automatic test_full_frame();
    logic band_end;
    start();
    step(1'b1, 1'b0);
    for (int l = 0; l < V_ACTIVE; l++) begin
      send_line(H_ACTIVE);
      band_end = ((l % 4) == 3);
      n_checks++; if (bus.oBandDone !== band_end) begin n_fail++; $display("FAIL frame_band_done l%0d got %b exp %b", l, bus.oBandDone, band_end); end
      n_checks++; if (bus.oV_Duty !== !band_end) begin n_fail++; $display("FAIL frame_v_duty l%0d got %b exp %b", l, bus.oV_Duty, !band_end); end
      n_checks++; if (bus.oBandIdx !== 1'(l / 4)) begin n_fail++; $display("FAIL frame_band_idx l%0d got %0d exp %0d", l, bus.oBandIdx, l / 4); end
      n_checks++; if (bus.oFrameDone !== (l == 7)) begin n_fail++; $display("FAIL frame_done l%0d got %b exp %b", l, bus.oFrameDone, (l == 7)); end
      step(1'b0, 1'b0);
      if (l == V_ACTIVE - 1) begin
        n_checks++; if (bus.oV_Duty !== 1'b0 || bus.oBandIdx !== 1'b0 || bus.oBandDone !== 1'b0) begin n_fail++; $display("FAIL frame_idle got v=%b idx=%0d done=%b exp v=0 idx=0 done=0", bus.oV_Duty, bus.oBandIdx, bus.oBandDone); end
      end else begin
        n_checks++; if (bus.oV_Duty !== 1'b1 || bus.oBandIdx !== 1'((l + 1) / 4)) begin n_fail++; $display("FAIL frame_next l%0d got v=%b idx=%0d exp v=1 idx=%0d", l, bus.oV_Duty, bus.oBandIdx, (l + 1) / 4); end
      end
    end
    n_checks++; if (bus.oErr !== 1'b0) begin n_fail++; $display("FAIL frame_err got %b exp 0", bus.oErr); end
  endtask

  task automatic test_long_line();
    logic [23:0] exp;
    start();
    step(1'b1, 1'b0);
    for (int p = 0; p < H_ACTIVE + 2; p++) begin
      step(1'b0, 1'b1);
      exp = (p < H_ACTIVE) ? (24'h1 << (p / 2)) : 24'h0;
      n_checks++; if (bus.oH_Duty !== exp) begin n_fail++; $display("FAIL long_h_duty px%0d got %h exp %h", p, bus.oH_Duty, exp); end
    end
    step(1'b0, 1'b0);
    n_checks++; if (bus.oErr !== ERR_ON) begin n_fail++; $display("FAIL long_err_set got %b exp %b", bus.oErr, ERR_ON); end
    step(1'b0, 1'b0);
    send_line(H_ACTIVE);
    step(1'b0, 1'b0);
    n_checks++; if (bus.oErr !== ERR_ON) begin n_fail++; $display("FAIL long_err_sticky got %b exp %b", bus.oErr, ERR_ON); end
    iRST = 1'b0;
    step(1'b0, 1'b0);
    n_checks++; if (bus.oErr !== 1'b0) begin n_fail++; $display("FAIL long_err_cleared got %b exp 0", bus.oErr); end
    iRST = 1'b1;
  endtask

  task automatic test_vsync_abort();
    start();
    step(1'b1, 1'b0);
    send_line(H_ACTIVE); step(1'b0, 1'b0);
    send_line(H_ACTIVE); step(1'b0, 1'b0);
    for (int p = 0; p < 10; p++) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    n_checks++; if (bus.oV_Duty !== 1'b0 || bus.oBandDone !== 1'b0 || bus.oH_Duty !== 24'h0) begin n_fail++; $display("FAIL abort_gap got v=%b done=%b h=%h exp v=0 done=0 h=0", bus.oV_Duty, bus.oBandDone, bus.oH_Duty); end
    step(1'b0, 1'b0);
    n_checks++; if (bus.oV_Duty !== 1'b1 || bus.oBandIdx !== 1'b0) begin n_fail++; $display("FAIL abort_restart got v=%b idx=%0d exp v=1 idx=0", bus.oV_Duty, bus.oBandIdx); end
    for (int l = 0; l < 4; l++) begin
      send_line(H_ACTIVE);
      n_checks++; if (bus.oBandDone !== (l == 3)) begin n_fail++; $display("FAIL abort_band_done l%0d got %b exp %b", l, bus.oBandDone, (l == 3)); end
      step(1'b0, 1'b0);
    end
    n_checks++; if (bus.oErr !== ERR_ON) begin n_fail++; $display("FAIL abort_err got %b exp %b", bus.oErr, ERR_ON); end
  endtask

  task automatic test_reset_mid();
    start();
    step(1'b1, 1'b0);
    for (int l = 0; l < 4; l++) begin
      send_line(H_ACTIVE);
      step(1'b0, 1'b0);
    end
    n_checks++; if (bus.oBandIdx !== 1'b1) begin n_fail++; $display("FAIL mid_band1 got %0d exp 1", bus.oBandIdx); end
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    iRST = 1'b0;
    step(1'b0, 1'b1);
    n_checks++; if (bus.oH_Duty !== 24'h0 || bus.oV_Duty !== 1'b0 || bus.oBandIdx !== 1'b0 || bus.oBandDone !== 1'b0 || bus.oFrameDone !== 1'b0) begin n_fail++; $display("FAIL mid_reset got h=%h v=%b idx=%0d done=%b fd=%b exp all 0", bus.oH_Duty, bus.oV_Duty, bus.oBandIdx, bus.oBandDone, bus.oFrameDone); end
    iRST = 1'b1;
    for (int p = 0; p < H_ACTIVE; p++) begin
      step(1'b0, 1'b1);
      n_checks++; if (bus.oH_Duty !== 24'h0) begin n_fail++; $display("FAIL mid_no_vsync px%0d got %h exp 0", p, bus.oH_Duty); end
    end
    step(1'b0, 1'b0);
    n_checks++; if (bus.oBandDone !== 1'b0 || bus.oV_Duty !== 1'b0) begin n_fail++; $display("FAIL mid_idle got done=%b v=%b exp 0 0", bus.oBandDone, bus.oV_Duty); end
  endtask

  task automatic test_vsync_de_same();
    logic [23:0] exp;
    start();
    step(1'b1, 1'b1);
    n_checks++; if (bus.oH_Duty !== 24'h0 || bus.oV_Duty !== 1'b1) begin n_fail++; $display("FAIL same_drop got h=%h v=%b exp h=0 v=1", bus.oH_Duty, bus.oV_Duty); end
    for (int p = 0; p < H_ACTIVE; p++) begin
      step(1'b0, 1'b1);
      exp = 24'h1 << (p / 2);
      n_checks++; if (bus.oH_Duty !== exp) begin n_fail++; $display("FAIL same_h_duty px%0d got %h exp %h", p, bus.oH_Duty, exp); end
    end
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    n_checks++; if (bus.oErr !== 1'b0) begin n_fail++; $display("FAIL same_err got %b exp 0", bus.oErr); end
  endtask

  task automatic test_de_band_end();
    start();
    step(1'b1, 1'b0);
    for (int l = 0; l < 3; l++) begin
      send_line(H_ACTIVE);
      step(1'b0, 1'b0);
    end
    send_line(H_ACTIVE);
    n_checks++; if (bus.oBandDone !== 1'b1) begin n_fail++; $display("FAIL be_done got %b exp 1", bus.oBandDone); end
    step(1'b0, 1'b1);
    n_checks++; if (bus.oH_Duty !== 24'h0) begin n_fail++; $display("FAIL be_drop got %h exp 0", bus.oH_Duty); end
    n_checks++; if (bus.oErr !== ERR_ON) begin n_fail++; $display("FAIL be_err got %b exp %b", bus.oErr, ERR_ON); end
    step(1'b0, 1'b0);
  endtask

  initial begin
    bus.iVSync = 1'b0;
    bus.iDE    = 1'b0;
    test_reset();
    test_first_line();
    test_full_frame();
    test_long_line();
    test_vsync_abort();
    test_reset_mid();
    test_vsync_de_same();
    test_de_band_end();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
